// File: rtl/seed_cursor_select.sv
// -----------------------------------------------------------------------------
// seed_cursor_select
//
// Purpose:
//   Seed-entry controller for the Game of Life LED grid. The player moves a
//   wrapping cursor over a ROWS x COLS grid with direction keys and confirms
//   cells with a select key. Each confirmed cell raises its bit in
//   selectingLightConfirmed. The bit stays high until the downstream cell
//   FSMs have sampled it on a game tick. Once the game is started, all seeding
//   is blocked until reset.
//
// Parameters:
//   ROWS, COLS  grid dimensions (each >= 2; need not be powers of two)
//
// Ports:
//   clk                     system clock
//   reset                   asynchronous active-high reset
//   keyUp/Down/Left/Right   raw active-high direction keys (asynchronous)
//   keySelect               raw active-high select key (asynchronous)
//   startGameSwitch         level, high = game running (asynchronous)
//   tickEnable              one-cycle game-step enable shared with the cell FSMs
//   selectingLightConfirmed per-cell confirm, bit index = row*COLS+col
//   cursorRow, cursorCol    current cursor position
//   cursorMarker            one-hot cursor overlay for the LED display
//
// Optional build macro:
//   CURSOR_BLINK_EN  when defined, the cursor overlay blinks. A blink flop
//                    toggles on every tickEnable in SETUP, and the overlay is
//                    shown only while that flop is 1. When undefined, the
//                    overlay is shown continuously in SETUP.
// -----------------------------------------------------------------------------
module seed_cursor_select #(
  parameter int ROWS = 8,
  parameter int COLS = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      keyUp,
  input  logic                      keyDown,
  input  logic                      keyLeft,
  input  logic                      keyRight,
  input  logic                      keySelect,
  input  logic                      startGameSwitch,
  input  logic                      tickEnable,
  output logic [ROWS*COLS-1:0]      selectingLightConfirmed,
  output logic [$clog2(ROWS)-1:0]   cursorRow,
  output logic [$clog2(COLS)-1:0]   cursorCol,
  output logic [ROWS*COLS-1:0]      cursorMarker
);

  localparam int N_CELLS = ROWS * COLS;
  localparam int RW      = $clog2(ROWS);
  localparam int CW      = $clog2(COLS);
  localparam int N_KEYS  = 5;

  // Bit positions inside the conditioned key vector.
  localparam int K_UP    = 0;
  localparam int K_DOWN  = 1;
  localparam int K_LEFT  = 2;
  localparam int K_RIGHT = 3;
  localparam int K_SEL   = 4;

  localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);

  typedef enum logic {
    ST_SETUP  = 1'b0,
    ST_LOCKED = 1'b1
  } state_t;

  // ---------------------------------------------------------------------------
  // Key conditioning: 2-flop synchronizer, history flop, registered rise pulse.
  // A raw rise shows up as a one-cycle edge_q pulse three cycles later. A held
  // key produces only that single pulse.
  // ---------------------------------------------------------------------------
  logic [N_KEYS-1:0] key_raw;
  logic [N_KEYS-1:0] key_sync1_q;
  logic [N_KEYS-1:0] key_sync2_q;
  logic [N_KEYS-1:0] key_prev_q;
  logic [N_KEYS-1:0] key_edge_q;

  assign key_raw = {keySelect, keyRight, keyLeft, keyDown, keyUp};

  genvar gi;
  generate
    for (gi = 0; gi < N_KEYS; gi++) begin : g_key
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          key_sync1_q[gi] <= 1'b0;
          key_sync2_q[gi] <= 1'b0;
          key_prev_q[gi]  <= 1'b0;
          key_edge_q[gi]  <= 1'b0;
        end else begin
          key_sync1_q[gi] <= key_raw[gi];
          key_sync2_q[gi] <= key_sync1_q[gi];
          key_prev_q[gi]  <= key_sync2_q[gi];
          key_edge_q[gi]  <= key_sync2_q[gi] & ~key_prev_q[gi];
        end
      end
    end
  endgenerate

  // The start switch is a level, so it only needs synchronizing.
  logic sw_sync1_q;
  logic sw_sync2_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_sync1_q <= 1'b0;
      sw_sync2_q <= 1'b0;
    end else begin
      sw_sync1_q <= startGameSwitch;
      sw_sync2_q <= sw_sync1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Core state
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [RW-1:0]        row_q, row_d;
  logic [CW-1:0]        col_q, col_d;
  logic [N_CELLS-1:0]   pend_q, pend_d;
  logic [N_CELLS-1:0]   cell_hit;
  logic                 blink;

  // One-hot decode of the current cursor position. It is used both for
  // selection and for the display overlay. Comparing against per-cell
  // constants avoids a row*COLS multiplier.
  generate
    for (gi = 0; gi < N_CELLS; gi++) begin : g_cell
      localparam int CELL_R = gi / COLS;
      localparam int CELL_C = gi % COLS;
      assign cell_hit[gi] = (row_q == RW'(CELL_R)) && (col_q == CW'(CELL_C));
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    pend_d  = pend_q;

    case (state_q)
      ST_SETUP: begin
        if (sw_sync2_q) begin
          // Entering LOCKED drops any seeds that were not yet ticked. This
          // matches the cell FSMs, which give the start switch priority over
          // the confirm input.
          state_d = ST_LOCKED;
          pend_d  = '0;
        end else begin
          // The cell FSMs sample the current vector on this tick, so every
          // bit already raised has been consumed.
          if (tickEnable) begin
            pend_d = '0;
          end
          // A select made on a tick cycle lands after the clear. It therefore
          // survives until the next tick. cell_hit reflects the cursor before
          // any same-cycle move.
          if (key_edge_q[K_SEL]) begin
            pend_d = pend_d | cell_hit;
          end

          // Only one move per cycle. Up > Down > Left > Right.
          if (key_edge_q[K_UP]) begin
            row_d = (row_q == '0) ? ROW_MAX : row_q - RW'(1);
          end else if (key_edge_q[K_DOWN]) begin
            row_d = (row_q == ROW_MAX) ? '0 : row_q + RW'(1);
          end else if (key_edge_q[K_LEFT]) begin
            col_d = (col_q == '0) ? COL_MAX : col_q - CW'(1);
          end else if (key_edge_q[K_RIGHT]) begin
            col_d = (col_q == COL_MAX) ? '0 : col_q + CW'(1);
          end
        end
      end

      ST_LOCKED: begin
        // Only reset leaves LOCKED. Keys and the switch level are ignored.
        pend_d = '0;
      end

      default: begin
        state_d = ST_SETUP;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SETUP;
      row_q   <= '0;
      col_q   <= '0;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pend_q  <= pend_d;
    end
  end

`ifdef CURSOR_BLINK_EN
  logic blink_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_q <= 1'b1;
    end else if ((state_q == ST_SETUP) && tickEnable) begin
      blink_q <= ~blink_q;
    end
  end

  assign blink = blink_q;
`else
  assign blink = 1'b1;
`endif

  // ---------------------------------------------------------------------------
  // Outputs: all are registered state or a decode of registered state only.
  // ---------------------------------------------------------------------------
  assign selectingLightConfirmed = pend_q;
  assign cursorRow               = row_q;
  assign cursorCol               = col_q;
  assign cursorMarker            = ((state_q == ST_SETUP) && blink) ? cell_hit : '0;

endmodule

// File: tb/tb_seed_cursor_select.sv
module tb_seed_cursor_select;

  localparam int ROWS = 8;
  localparam int COLS = 8;
  localparam int N    = ROWS * COLS;

  // Raw input bit positions used by the stimulus vectors.
  localparam logic [5:0] KU = 6'b000001;
  localparam logic [5:0] KD = 6'b000010;
  localparam logic [5:0] KL = 6'b000100;
  localparam logic [5:0] KR = 6'b001000;
  localparam logic [5:0] KS = 6'b010000;
  localparam logic [5:0] SW = 6'b100000;

  logic                    clk = 1'b0;
  logic                    reset;
  logic                    keyUp, keyDown, keyLeft, keyRight, keySelect;
  logic                    startGameSwitch, tickEnable;
  logic [N-1:0]            selectingLightConfirmed;
  logic [$clog2(ROWS)-1:0] cursorRow;
  logic [$clog2(COLS)-1:0] cursorCol;
  logic [N-1:0]            cursorMarker;

  always #5 clk = ~clk;

  seed_cursor_select #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .keyUp                  (keyUp),
    .keyDown                (keyDown),
    .keyLeft                (keyLeft),
    .keyRight               (keyRight),
    .keySelect              (keySelect),
    .startGameSwitch        (startGameSwitch),
    .tickEnable             (tickEnable),
    .selectingLightConfirmed(selectingLightConfirmed),
    .cursorRow              (cursorRow),
    .cursorCol              (cursorCol),
    .cursorMarker           (cursorMarker)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  // Raw input history per clock edge. A key rise takes effect three edges
  // after it is sampled. The switch level takes effect two edges after.
  logic [5:0] hist [4];
  int         m_row, m_col;
  bit         m_pend [N];
  bit         m_locked;
  bit         m_blink;

  task automatic model_reset();
    for (int i = 0; i < 4; i++) hist[i] = '0;
    for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
    m_row = 0; m_col = 0; m_locked = 1'b0; m_blink = 1'b1;
  endtask

  task automatic model_edge(input logic [5:0] raw, input bit tick);
    logic [5:0] rise;
    bit         sw;
    rise = hist[2] & ~hist[3];
    sw   = hist[1][5];
    if (!m_locked) begin
      if (tick) m_blink = !m_blink;
      if (sw) begin
        m_locked = 1'b1;
        for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
      end else begin
        if (tick) for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
        if (rise[4]) m_pend[m_row * COLS + m_col] = 1'b1;
        if      (rise[0]) m_row = (m_row + ROWS - 1) % ROWS;
        else if (rise[1]) m_row = (m_row + 1) % ROWS;
        else if (rise[2]) m_col = (m_col + COLS - 1) % COLS;
        else if (rise[3]) m_col = (m_col + 1) % COLS;
      end
    end
    hist[3] = hist[2]; hist[2] = hist[1]; hist[1] = hist[0]; hist[0] = raw;
  endtask

  function automatic logic [63:0] exp_confirm();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < N; i++) if (m_pend[i]) v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [63:0] exp_marker();
    logic [63:0] v;
    v = '0;
    if (!m_locked) begin
`ifdef CURSOR_BLINK_EN
      if (m_blink) v[m_row * COLS + m_col] = 1'b1;
`else
      v[m_row * COLS + m_col] = 1'b1;
`endif
    end
    return v;
  endfunction

  task automatic check_all(input string where);
    check({where, ".row"},     64'(cursorRow),               64'(m_row));
    check({where, ".col"},     64'(cursorCol),               64'(m_col));
    check({where, ".confirm"}, 64'(selectingLightConfirmed), exp_confirm());
    check({where, ".marker"},  64'(cursorMarker),            exp_marker());
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [5:0] raw, input bit tick);
    keyUp = raw[0]; keyDown = raw[1]; keyLeft = raw[2]; keyRight = raw[3];
    keySelect = raw[4]; startGameSwitch = raw[5]; tickEnable = tick;
  endtask

  // Called at a negedge: apply inputs, clock once, then compare at the next negedge.
  task automatic step(input logic [5:0] raw, input bit tick);
    drive(raw, tick);
    @(posedge clk);
    model_edge(raw, tick);
    @(negedge clk);
    check_all("step");
  endtask

  task automatic pulse(input logic [5:0] k);
    step(k, 1'b0);
    step('0, 1'b0);
  endtask

  task automatic do_reset();
    drive('0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("reset");
  endtask

  logic [5:0] rnd_raw;
  bit         rnd_tick;

  initial begin
    reset = 1'b1;
    drive('0, 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("rst.row",     64'(cursorRow), 64'd0);
    check("rst.col",     64'(cursorCol), 64'd0);
    check("rst.confirm", 64'(selectingLightConfirmed), 64'd0);
    check("rst.marker",  64'(cursorMarker), 64'd1);

    // Single left press wraps column, then a long held right moves once.
    step(KL, 1'b0);
    repeat (4) step('0, 1'b0);
    check("left_wrap.col", 64'(cursorCol), 64'(COLS - 1));
    check("left_wrap.row", 64'(cursorRow), 64'd0);
    repeat (20) step(KR, 1'b0);
    repeat (3) step('0, 1'b0);
    check("held_right.col", 64'(cursorCol), 64'd0);

    // Down x3, Right x2, select -> cell 26; cleared by the first tick.
    do_reset();
    repeat (3) pulse(KD);
    repeat (2) pulse(KR);
    pulse(KS);
    repeat (4) step('0, 1'b0);
    check("sel26.confirm", 64'(selectingLightConfirmed), 64'd1 << 26);
    step('0, 1'b1);
    check("sel26.drained", 64'(selectingLightConfirmed), 64'd0);

    // Select edge landing on a tick cycle survives that tick.
    step(KS, 1'b0);
    step('0, 1'b0);
    step('0, 1'b0);
    step('0, 1'b1);
    check("sel_tick.kept", 64'(selectingLightConfirmed), 64'd1 << 26);
    repeat (2) step('0, 1'b0);
    step('0, 1'b1);
    check("sel_tick.drained", 64'(selectingLightConfirmed), 64'd0);

    // Up and Right at once: Up wins.
    do_reset();
    step(KU | KR, 1'b0);
    repeat (4) step('0, 1'b0);
    check("prio.row", 64'(cursorRow), 64'(ROWS - 1));
    check("prio.col", 64'(cursorCol), 64'd0);

    // Select cell 5, then lock before any tick.
    do_reset();
    repeat (5) pulse(KR);
    pulse(KS);
    repeat (5) step(SW, 1'b0);
    check("lock.confirm", 64'(selectingLightConfirmed), 64'd0);
    check("lock.marker",  64'(cursorMarker), 64'd0);
    step(SW | KL, 1'b0); step(SW, 1'b0); step(SW | KU, 1'b0); step(SW | KS, 1'b1);
    repeat (4) step(SW, 1'b0);
    repeat (6) step('0, 1'b1);
    check("lock.col",    64'(cursorCol), 64'd5);
    check("lock.row",    64'(cursorRow), 64'd0);
    check("lock.marker2", 64'(cursorMarker), 64'd0);

    // Asynchronous reset between clock edges with a pending bit.
    do_reset();
    repeat (2) pulse(KR);
    pulse(KS);
    repeat (4) step('0, 1'b0);
    check("areset.pre", 64'(selectingLightConfirmed), 64'd1 << 2);
    drive('0, 1'b0);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("areset.row",     64'(cursorRow), 64'd0);
    check("areset.col",     64'(cursorCol), 64'd0);
    check("areset.confirm", 64'(selectingLightConfirmed), 64'd0);
    check("areset.marker",  64'(cursorMarker), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_all("areset.post");

    // Overlay behaviour across successive ticks.
    step('0, 1'b1);
`ifdef CURSOR_BLINK_EN
    check("blink.off", 64'(cursorMarker), 64'd0);
`else
    check("blink.off", 64'(cursorMarker), 64'd1);
`endif
    step('0, 1'b1);
    check("blink.on", 64'(cursorMarker), 64'd1);

    // Randomized traffic against the model, with a reset midway and a lock at the end.
    do_reset();
    rnd_raw = '0;
    for (int i = 0; i < 700; i++) begin
      for (int b = 0; b < 5; b++) if ($urandom_range(0, 4) == 0) rnd_raw[b] = ~rnd_raw[b];
      if (i >= 600 && $urandom_range(0, 29) == 0) rnd_raw[5] = ~rnd_raw[5];
      rnd_tick = ($urandom_range(0, 5) == 0);
      if (i == 300) do_reset();
      step(rnd_raw, rnd_tick);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
